mem_ctrl: RTL and testbench

Unified memory controller between the multicycle MIPS core's memory port and a single word-wide instruction/data RAM. It converts the core's address/write-data/write-enable port into a request/ready handshake. It inserts a programmable number of wait states to model a slow memory, so the core's controller FSM can stall on real latency. It also flags misaligned and out-of-range accesses instead of corrupting memory.

---
 rtl/mem_ctrl_pkg.sv | 15 +
 rtl/mem_ctrl_ram.sv | 34 +++
 rtl/mem_ctrl.sv | 119 +++++++++++
 tb/tb_mem_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the unified instruction/data memory controller.
//   mem_state_t : controller FSM states
//   CntW        : wait-state counter width (LATENCY range 0..7)
//   addr_ok()   : true when a byte address is word aligned and inside the RAM
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  localparam int unsigned CntW = 3;

  function automatic logic addr_ok(input logic [31:0] adr, input int unsigned depth);
    return (adr[1:0] == 2'b00) && (adr < (depth * 4));
  endfunction

endpackage

// File: rtl/mem_ctrl_ram.sv
// Single-port synchronous RAM, DEPTH x 32, with registered read.
// Ports:
//   clk      : clock, rising edge
//   i_en     : access enable for this edge
//   i_we     : 1 = write i_wdata, 0 = read into o_rdata
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : read data register; holds until the next enabled read
module mem_ctrl_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller between the multicycle core's memory port and a word-wide RAM.
// Turns a request into a ready pulse after LATENCY wait states and flags
// misaligned / out-of-range accesses without touching memory.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-low reset
//   req        : access request, sampled only in IDLE
//   we         : 1 = write, 0 = read (sampled with req)
//   adr, wdata : byte address and write data (sampled with req)
//   rdata      : read data, valid with ready on a read; held otherwise
//   ready      : one-cycle completion pulse
//   err        : access fault, valid with ready
//   busy       : controller not in IDLE
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_state_t      r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_we;
  logic [31:0]     r_adr, r_wdata;
  logic            r_ready, r_err;
  logic            r_rd_zero;

  logic            w_sample, w_access, w_ok, w_ram_en, w_we;
  logic [31:0]     w_adr, w_wdata, w_ram_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sample    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_sample    = 1'b1;
          w_cnt_nxt   = CntW'(LATENCY);
          w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - CntW'(1);
        if (r_cnt <= CntW'(1)) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // With LATENCY=0 the access happens on the sampling edge, so use live inputs in IDLE.
  assign w_adr   = (r_state == IDLE) ? adr   : r_adr;
  assign w_we    = (r_state == IDLE) ? we    : r_we;
  assign w_wdata = (r_state == IDLE) ? wdata : r_wdata;

  // Gate with reset so a request held during reset cannot reach the RAM.
  assign w_access = (w_state_nxt == RESP) && reset;
  assign w_ok     = addr_ok(w_adr, DEPTH);
  assign w_ram_en = w_access && w_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_sample) begin
        r_we    <= we;
        r_adr   <= adr;
        r_wdata <= wdata;
      end
      r_ready <= w_access;
      r_err   <= w_access && !w_ok;
      // Faulted reads return zero; the RAM read register is left untouched.
      if (w_access && !w_we) begin
        r_rd_zero <= !w_ok;
      end
    end
  end

  mem_ctrl_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_we   (w_we),
    .i_addr (w_adr[AW+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign rdata = r_rd_zero ? 32'h0000_0000 : w_ram_rdata;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench: two controllers (LATENCY=2 and LATENCY=0) against a
// word-array reference model; directed cases plus randomized accesses.
module tb_mem_ctrl;

  localparam int unsigned Depth = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we, ready, err, busy;
  logic [31:0] adr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl_mem [2][Depth];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  mem_ctrl #(
    .DEPTH  (Depth),
    .LATENCY(2)
  ) u_dut_l2 (
    .clk  (clk),
    .reset(reset),
    .req  (req[0]),
    .we   (we[0]),
    .adr  (adr[0]),
    .wdata(wdata[0]),
    .rdata(rdata[0]),
    .ready(ready[0]),
    .err  (err[0]),
    .busy (busy[0])
  );

  mem_ctrl #(
    .DEPTH  (Depth),
    .LATENCY(0)
  ) u_dut_l0 (
    .clk  (clk),
    .reset(reset),
    .req  (req[1]),
    .we   (we[1]),
    .adr  (adr[1]),
    .wdata(wdata[1]),
    .rdata(rdata[1]),
    .ready(ready[1]),
    .err  (err[1]),
    .busy (busy[1])
  );

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * Depth));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One full access on controller s, checking every cycle of its occupancy.
  task automatic access(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int   lat;
    logic f;
    lat = lat_of(s);
    f   = is_fault(a);
    if (!w) exp_rd[s] = f ? 32'h0 : mdl_mem[s][a[7:2]];
    @(negedge clk);
    req[s]   = 1'b1;
    we[s]    = w;
    adr[s]   = a;
    wdata[s] = d;
    for (int n = 1; n <= lat + 2; n++) begin
      @(negedge clk);
      req[s] = 1'b0;
      check({tag, "/ready"}, 32'(ready[s]), 32'(n == lat + 1));
      check({tag, "/busy"}, 32'(busy[s]), 32'(n <= lat + 1));
      if (n == lat + 1) begin
        check({tag, "/err"}, 32'(err[s]), 32'(f));
        if (!w) check({tag, "/rdata"}, rdata[s], exp_rd[s]);
      end
      if (n == lat + 2) check({tag, "/hold"}, rdata[s], exp_rd[s]);
    end
    if (w && !f) mdl_mem[s][a[7:2]] = d;
  endtask

  task automatic reset_both_rd();
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endtask

  initial begin
    int          kind;
    int          s;
    logic [31:0] a;
    int          rdy_q[$];

    reset    = 1'b0;
    req      = 2'b11;
    we       = 2'b00;
    adr[0]   = 32'h10;
    adr[1]   = 32'h0;
    wdata[0] = 32'h0;
    wdata[1] = 32'h0;
    reset_both_rd();

    // Reset held with req asserted.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check("rst/ready", 32'(ready[k]), 32'h0);
        check("rst/err", 32'(err[k]), 32'h0);
        check("rst/busy", 32'(busy[k]), 32'h0);
        check("rst/rdata", rdata[k], 32'h0);
      end
    end
    req   = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst/busy0", 32'(busy[0]), 32'h0);
    check("post_rst/busy1", 32'(busy[1]), 32'h0);

    // Fill both RAMs so every in-range word has a known value.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(Depth); i++)
        access(k, 1'b1, 32'(i * 4), $urandom, "fill");

    // Directed cases.
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, "wr10");
    access(0, 1'b0, 32'h10, 32'h0, "rd10");
    access(1, 1'b1, 32'h0, 32'h2002_0005, "l0_wr0");
    access(1, 1'b0, 32'h0, 32'h0, "l0_rd0");
    access(0, 1'b1, 32'h12, 32'hBAD0_BAD0, "wr_misal");
    access(0, 1'b0, 32'h10, 32'h0, "rd10_after_misal");
    access(0, 1'b0, 32'h100, 32'h0, "rd_oor");
    access(1, 1'b1, 32'h100, 32'h5555_AAAA, "l0_wr_oor");
    access(1, 1'b0, 32'h0, 32'h0, "l0_rd0_after_oor");

    // req held high: accesses every LATENCY+2 cycles, never two readies in a row.
    exp_rd[0] = mdl_mem[0][4];
    @(negedge clk);
    req[0] = 1'b1;
    we[0]  = 1'b0;
    adr[0] = 32'h10;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ready[0]) begin
        rdy_q.push_back(n);
        check("hold/rdata", rdata[0], exp_rd[0]);
      end
    end
    req[0] = 1'b0;
    @(negedge clk);
    check("hold/count", 32'(rdy_q.size()), 32'd3);
    for (int i = 0; i < rdy_q.size(); i++)
      check("hold/when", 32'(rdy_q[i]), 32'(3 + 4 * i));
    check("hold/drain_busy", 32'(busy[0]), 32'h0);

    // Reset during WAIT drops the pending write.
    @(negedge clk);
    req[0]   = 1'b1;
    we[0]    = 1'b1;
    adr[0]   = 32'h20;
    wdata[0] = 32'h1234_5678;
    @(negedge clk);
    req[0] = 1'b0;
    check("midrst/busy_before", 32'(busy[0]), 32'h1);
    reset = 1'b0;
    #1;
    check("midrst/ready", 32'(ready[0]), 32'h0);
    check("midrst/busy", 32'(busy[0]), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    reset_both_rd();
    check("midrst/rdata1", rdata[1], 32'h0);
    @(negedge clk);
    check("midrst/idle", 32'(busy[0]), 32'h0);
    access(0, 1'b0, 32'h20, 32'h0, "midrst_rd20");

    // Randomized traffic on both controllers.
    for (int t = 0; t < 80; t++) begin
      s    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      case (kind)
        0:       a = 32'($urandom_range(0, Depth - 1)) * 4 + 32'($urandom_range(1, 3));
        1:       a = 32'h100 + (32'($urandom_range(0, 32'hFFFF)) << 2);
        default: a = 32'($urandom_range(0, Depth - 1)) * 4;
      endcase
      access(s, 1'($urandom_range(0, 1)), a, $urandom, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
